// File: rtl/lc3b_dcache.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU mem_* port and 128-bit pmem_* lines.
// Optional hit/miss statistics counters are built only when LC3B_DCACHE_STATS_EN is defined.
module lc3b_dcache #(
  parameter int NUM_SETS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  mem_address,
  input  logic [15:0]  mem_wdata,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  input  logic         pmem_resp,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 12 - IDX_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WB    = 2'd1;
  localparam logic [1:0] S_ALLOC = 2'd2;

  logic [1:0]          state;
  logic [1:0]          next_state;
  logic [NUM_SETS-1:0] valid;
  logic [NUM_SETS-1:0] dirty;
  logic [TAG_W-1:0]    tags  [NUM_SETS];
  logic [127:0]        lines [NUM_SETS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [2:0]       word;
  logic [6:0]       lo_off;
  logic [6:0]       hi_off;
  logic             req;
  logic             hit;
  logic             idle_hit;
  logic             write_hit;
  logic             miss_detect;
  logic             fill;
  logic             wb_done;
  logic             unused_addr_bit;

  assign idx     = mem_address[IDX_W+3:4];
  assign tag     = mem_address[15:IDX_W+4];
  assign word    = mem_address[3:1];
  assign lo_off  = {word, 4'b0000};
  assign hi_off  = {word, 4'b1000};
  assign req     = mem_read | mem_write;
  assign hit     = valid[idx] && (tags[idx] == tag);

  assign idle_hit    = (state == S_IDLE) && req && hit;
  assign write_hit   = idle_hit && mem_write;
  assign miss_detect = (state == S_IDLE) && req && !hit;
  assign fill        = (state == S_ALLOC) && pmem_resp;
  assign wb_done     = (state == S_WB) && pmem_resp;

  assign unused_addr_bit = mem_address[0];

  // Next-state and port drive; outputs follow state so an async reset drops them at once
  always_comb begin
    next_state   = state;
    mem_resp     = 1'b0;
    mem_rdata    = 16'h0000;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 16'h0000;
    pmem_wdata   = 128'h0;
    case (state)
      S_IDLE: begin
        if (idle_hit) begin
          mem_resp = 1'b1;
          if (!mem_write) begin
            mem_rdata = lines[idx][lo_off +: 16];
          end else begin
            mem_rdata = 16'h0000;
          end
        end else if (miss_detect) begin
          next_state = (valid[idx] && dirty[idx]) ? S_WB : S_ALLOC;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_WB: begin
        pmem_write   = 1'b1;
        pmem_address = {tags[idx], idx, 4'b0000};
        pmem_wdata   = lines[idx];
        if (pmem_resp) begin
          next_state = S_ALLOC;
        end else begin
          next_state = S_WB;
        end
      end
      S_ALLOC: begin
        pmem_read    = 1'b1;
        pmem_address = {mem_address[15:4], 4'b0000};
        if (pmem_resp) begin
          next_state = S_IDLE;
        end else begin
          next_state = S_ALLOC;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Valid/dirty bookkeeping; these are the only per-line bits cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (wb_done) begin
      dirty[idx] <= 1'b0;
    end else if (write_hit) begin
      dirty[idx] <= 1'b1;
    end
  end

  // Tag and data arrays: line fill from memory or byte merge of a CPU write hit
  always_ff @(posedge clk) begin
    if (fill) begin
      lines[idx] <= pmem_rdata;
      tags[idx]  <= tag;
    end else if (write_hit) begin
      if (mem_byte_enable[0]) begin
        lines[idx][lo_off +: 8] <= mem_wdata[7:0];
      end
      if (mem_byte_enable[1]) begin
        lines[idx][hi_off +: 8] <= mem_wdata[15:8];
      end
    end
  end

`ifdef LC3B_DCACHE_STATS_EN
  logic [15:0] hits;
  logic [15:0] misses;
  logic        after_fill;

  // Saturating counters; the hit that completes a refill is not a true hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits       <= 16'h0000;
      misses     <= 16'h0000;
      after_fill <= 1'b0;
    end else begin
      if (fill) begin
        after_fill <= 1'b1;
      end else if (idle_hit) begin
        after_fill <= 1'b0;
      end
      if (idle_hit && !after_fill && (hits != 16'hFFFF)) begin
        hits <= hits + 16'h0001;
      end
      if (miss_detect && (misses != 16'hFFFF)) begin
        misses <= misses + 16'h0001;
      end
    end
  end

  assign hit_count  = hits;
  assign miss_count = misses;
`else
  assign hit_count  = 16'h0000;
  assign miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_lc3b_dcache.sv
// Self-checking bench for lc3b_dcache: directed scenarios plus randomized traffic against a
// word-level cache/memory model; expectations for counters follow LC3B_DCACHE_STATS_EN.
module tb_lc3b_dcache;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  mem_address;
  logic [15:0]  mem_wdata;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic         pmem_resp;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  lc3b_dcache #(.NUM_SETS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: per-set words, plus a sparse backing memory keyed by line number
  bit           m_valid [8];
  bit           m_dirty [8];
  logic [8:0]   m_tag   [8];
  logic [15:0]  m_word  [8][8];
  logic [127:0] mem_lines [int];
  int           m_hits;
  int           m_misses;

  function automatic logic [127:0] mem_get(int ln);
    if (!mem_lines.exists(ln)) mem_lines[ln] = {$urandom, $urandom, $urandom, $urandom};
    return mem_lines[ln];
  endfunction

  function automatic logic [127:0] model_line(int s);
    logic [127:0] r;
    for (int w = 0; w < 8; w++) r[16*w +: 16] = m_word[s][w];
    return r;
  endfunction

  function automatic logic [15:0] exp_hits();
`ifdef LC3B_DCACHE_STATS_EN
    return (m_hits > 65535) ? 16'hFFFF : m_hits[15:0];
`else
    return 16'h0000;
`endif
  endfunction

  function automatic logic [15:0] exp_misses();
`ifdef LC3B_DCACHE_STATS_EN
    return (m_misses > 65535) ? 16'hFFFF : m_misses[15:0];
`else
    return 16'h0000;
`endif
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic idle_inputs();
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = 16'h0000;
    mem_wdata       = 16'h0000;
    mem_byte_enable = 2'b00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One CPU access with the bench acting as memory; wb_lat/al_lat are pmem phase lengths in cycles
  task automatic access(input logic [15:0] a, input bit wr, input logic [15:0] wd,
                        input logic [1:0] be, input int wb_lat, input int al_lat,
                        output logic [15:0] rd);
    int s, w;
    logic [8:0]   tg;
    logic [15:0]  exp_addr;
    logic [127:0] line;
    bit           hit;
    s   = int'(a[6:4]);
    w   = int'(a[3:1]);
    tg  = a[15:7];
    hit = m_valid[s] && (m_tag[s] == tg);
    mem_address = a; mem_write = wr; mem_read = !wr; mem_wdata = wd; mem_byte_enable = be;
    if (!hit) begin
      m_misses++;
      @(negedge clk);
      checks++;
      if ({mem_resp, pmem_read, pmem_write} !== 3'b000) begin
        errors++;
        $display("FAIL miss_detect addr=%h got resp/rd/wr=%b want 000", a, {mem_resp, pmem_read, pmem_write});
      end
      step();
      if (m_valid[s] && m_dirty[s]) begin
        exp_addr = {m_tag[s], s[2:0], 4'h0};
        line = model_line(s);
        for (int c = 0; c < wb_lat; c++) begin
          @(negedge clk);
          checks++;
          if ({mem_resp, pmem_read, pmem_write, pmem_address} !== {3'b001, exp_addr}) begin
            errors++;
            $display("FAIL writeback_ctrl got %b/%h want 001/%h", {mem_resp, pmem_read, pmem_write}, pmem_address, exp_addr);
          end
          checks++;
          if (pmem_wdata !== line) begin
            errors++;
            $display("FAIL writeback_data got %h want %h", pmem_wdata, line);
          end
          if (c == wb_lat - 1) pmem_resp = 1'b1;
          step();
          pmem_resp = 1'b0;
        end
        mem_lines[int'(exp_addr[15:4])] = line;
        m_dirty[s] = 1'b0;
      end
      line = mem_get(int'(a[15:4]));
      for (int c = 0; c < al_lat; c++) begin
        @(negedge clk);
        checks++;
        if ({mem_resp, pmem_read, pmem_write, pmem_address} !== {3'b010, a[15:4], 4'h0}) begin
          errors++;
          $display("FAIL allocate_ctrl got %b/%h want 010/%h", {mem_resp, pmem_read, pmem_write}, pmem_address, {a[15:4], 4'h0});
        end
        if (c == al_lat - 1) begin
          pmem_rdata = line;
          pmem_resp  = 1'b1;
        end
        step();
        pmem_resp  = 1'b0;
        pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
      for (int k = 0; k < 8; k++) m_word[s][k] = line[16*k +: 16];
      m_valid[s] = 1'b1;
      m_dirty[s] = 1'b0;
      m_tag[s]   = tg;
    end
    @(negedge clk);
    checks++;
    if ({mem_resp, pmem_read, pmem_write} !== 3'b100) begin
      errors++;
      $display("FAIL hit_resp addr=%h got resp/rd/wr=%b want 100", a, {mem_resp, pmem_read, pmem_write});
    end
    rd = mem_rdata;
    if (!wr) begin
      checks++;
      if (mem_rdata !== m_word[s][w]) begin
        errors++;
        $display("FAIL read_data addr=%h got %h want %h", a, mem_rdata, m_word[s][w]);
      end
    end else begin
      if (be[0]) m_word[s][w][7:0]  = wd[7:0];
      if (be[1]) m_word[s][w][15:8] = wd[15:8];
      m_dirty[s] = 1'b1;
    end
    if (hit) m_hits++;
    step();
    idle_inputs();
    checks++;
    if ({hit_count, miss_count} !== {exp_hits(), exp_misses()}) begin
      errors++;
      $display("FAIL counters got hit=%h miss=%h want hit=%h miss=%h", hit_count, miss_count, exp_hits(), exp_misses());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    pmem_resp  = 1'b0;
    pmem_rdata = 128'h0;
    model_reset();
    #13;
    checks++;
    if ({mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address, hit_count, miss_count} !== 67'h0 ||
        pmem_wdata !== 128'h0) begin
      errors++;
      $display("FAIL reset_outputs resp=%b rdata=%h rd=%b wr=%b addr=%h wdata=%h hit=%h miss=%h want all 0",
               mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata, hit_count, miss_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_directed();
    logic [15:0] rd;
    logic [127:0] l;
    l = {$urandom, $urandom, $urandom, $urandom};
    l[31:16] = 16'hBEEF;
    mem_lines[int'(16'h0004)] = l;
    access(16'h0042, 1'b0, 16'h0000, 2'b00, 1, 3, rd);
    checks++;
    if (rd !== 16'hBEEF) begin errors++; $display("FAIL first_fill got %h want BEEF", rd); end
    access(16'h0042, 1'b1, 16'h1234, 2'b01, 1, 1, rd);
    access(16'h0042, 1'b0, 16'h0000, 2'b11, 1, 1, rd);
    checks++;
    if (rd !== 16'hBE34) begin errors++; $display("FAIL byte_merge got %h want BE34", rd); end
    access(16'h00C2, 1'b0, 16'h0000, 2'b00, 2, 2, rd);
    // Set 4 is now clean with tag 1: refetch of 0x0042 sees the written-back word
    access(16'h0042, 1'b0, 16'h0000, 2'b00, 1, 1, rd);
    checks++;
    if (rd !== 16'hBE34) begin errors++; $display("FAIL clean_conflict got %h want BE34", rd); end
    access(16'h0042, 1'b1, 16'hFFFF, 2'b00, 1, 1, rd);
    access(16'h0042, 1'b0, 16'h0000, 2'b00, 1, 1, rd);
    checks++;
    if (rd !== 16'hBE34) begin errors++; $display("FAIL be_zero_write got %h want BE34", rd); end
  endtask

  task automatic test_reset_mid_miss();
    logic [15:0] rd;
    logic [15:0] a;
    int misses_before;
    a = 16'hF824;
    mem_address = a; mem_read = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    checks++;
    if (pmem_read !== 1'b1) begin errors++; $display("FAIL pre_abort_read got %b want 1", pmem_read); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pmem_read, pmem_write, pmem_address} !== 18'h0) begin
      errors++;
      $display("FAIL abort_drop got rd=%b wr=%b addr=%h want 0", pmem_read, pmem_write, pmem_address);
    end
    idle_inputs();
    model_reset();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    misses_before = m_misses;
    access(a, 1'b0, 16'h0000, 2'b00, 1, 2, rd);
    checks++;
    if (m_misses !== misses_before + 1 || miss_count !== exp_misses()) begin
      errors++;
      $display("FAIL reread_miss got miss_count=%h want %h", miss_count, exp_misses());
    end
  endtask

  task automatic test_random();
    logic [15:0] rd;
    logic [15:0] a;
    for (int i = 0; i < 300; i++) begin
      a = {7'($urandom_range(0, 3)), 9'($urandom)};
      access(a, 1'($urandom), 16'($urandom), 2'($urandom), $urandom_range(1, 3),
             $urandom_range(1, 4), rd);
      if ($urandom_range(0, 3) == 0) step();
    end
  endtask

  task automatic test_saturation();
    logic [15:0] rd;
    access(16'h0312, 1'b0, 16'h0000, 2'b00, 1, 1, rd);
`ifdef LC3B_DCACHE_STATS_EN
    mem_address = 16'h0312; mem_read = 1'b1;
    repeat (70000) step();
    m_hits += 70000;
    idle_inputs();
    step();
    checks++;
    if (hit_count !== 16'hFFFF || hit_count !== exp_hits()) begin
      errors++;
      $display("FAIL hit_saturate got %h want FFFF", hit_count);
    end
`else
    checks++;
    if ({hit_count, miss_count} !== 32'h0) begin
      errors++;
      $display("FAIL stats_disabled got hit=%h miss=%h want 0", hit_count, miss_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_miss();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
